// File: rtl/led_pkg.sv
// Shared types and seed helper for the LED pattern engine.
package led_pkg;

    typedef enum logic [1:0] {
        MODE_ROTL   = 2'd0,
        MODE_ROTR   = 2'd1,
        MODE_BOUNCE = 2'd2,
        MODE_COUNT  = 2'd3
    } led_mode_e;

    typedef enum logic {
        DIR_LEFT  = 1'b0,
        DIR_RIGHT = 1'b1
    } led_dir_e;

    localparam int unsigned MaxLeds = 32;

    // Starting pattern for a mode; callers truncate to their LED count.
    function automatic logic [MaxLeds-1:0] seed(led_mode_e mode, int unsigned n);
        logic [MaxLeds-1:0] s;
        case (mode)
            MODE_ROTR:  s = MaxLeds'(1) << (n - 1);
            MODE_COUNT: s = '0;
            default:    s = MaxLeds'(1);
        endcase
        return s;
    endfunction

endpackage

// File: rtl/btn_debounce.sv
// Two-flop synchroniser followed by a stability counter for an active-low push button.
module btn_debounce #(
    parameter int unsigned DEB_CYCLES = 250_000
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic btn_i,
    output logic btn_o
);

    localparam int unsigned CntW = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
    localparam logic [CntW-1:0] CntMax = CntW'(DEB_CYCLES - 1);

    logic            sync1_q, sync2_q;
    logic            btn_q, btn_d;
    logic [CntW-1:0] cnt_q, cnt_d;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
            btn_q   <= 1'b1;
            cnt_q   <= '0;
        end else begin
            sync1_q <= btn_i;
            sync2_q <= sync1_q;
            btn_q   <= btn_d;
            cnt_q   <= cnt_d;
        end
    end

    // Any cycle where the synced level matches the accepted level restarts the count.
    always_comb begin
        btn_d = btn_q;
        cnt_d = '0;
        if (sync2_q != btn_q) begin
            if (cnt_q == CntMax) begin
                btn_d = sync2_q;
            end else begin
                cnt_d = cnt_q + CntW'(1);
            end
        end
    end

    assign btn_o = btn_q;

endmodule

// File: rtl/led_pattern_gen.sv
// LED pattern engine: prescaled stepping through rotate, bounce or count patterns,
// with a debounced restart button and a pause input.
module led_pattern_gen
    import led_pkg::*;
#(
    parameter int unsigned N_LEDS     = 8,
    parameter int unsigned DIV        = 12_500_000,
    parameter int unsigned DEB_CYCLES = 250_000
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              btn_i,
    input  logic [1:0]        mode_i,
    input  logic              pause_i,
    output logic [N_LEDS-1:0] led_o,
    output logic              step_o
);

    localparam int unsigned CntW = $clog2(DIV);
    localparam logic [CntW-1:0] CntMax = CntW'(DIV - 1);

    logic              btn_db;
    led_mode_e         mode_in;
    led_mode_e         mode_q, mode_d;
    led_dir_e          dir_q, dir_d, nxt_dir;
    logic [CntW-1:0]   cnt_q, cnt_d;
    logic [N_LEDS-1:0] led_q, led_d, nxt, seed_w;
    logic              step_q, step_d;

    btn_debounce #(
        .DEB_CYCLES(DEB_CYCLES)
    ) u_btn_debounce (
        .clk_i (clk_i),
        .rst_ni(rst_ni),
        .btn_i (btn_i),
        .btn_o (btn_db)
    );

    assign mode_in = led_mode_e'(mode_i);
    assign seed_w  = N_LEDS'(seed(mode_in, N_LEDS));

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q  <= '0;
            mode_q <= MODE_ROTL;
            dir_q  <= DIR_LEFT;
            led_q  <= N_LEDS'(1);
            step_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            mode_q <= mode_d;
            dir_q  <= dir_d;
            led_q  <= led_d;
            step_q <= step_d;
        end
    end

    // Step function for the current mode.
    always_comb begin
        nxt     = led_q;
        nxt_dir = dir_q;
        unique case (mode_q)
            MODE_ROTL: nxt = {led_q[N_LEDS-2:0], led_q[N_LEDS-1]};
            MODE_ROTR: nxt = {led_q[0], led_q[N_LEDS-1:1]};
            MODE_BOUNCE: begin
                if (dir_q == DIR_LEFT) begin
                    nxt = led_q << 1;
                    if (led_q[N_LEDS-2]) nxt_dir = DIR_RIGHT;
                end else begin
                    nxt = led_q >> 1;
                    if (led_q[1]) nxt_dir = DIR_LEFT;
                end
            end
            MODE_COUNT: nxt = led_q + N_LEDS'(1);
        endcase
        // A corrupted shift pattern restarts from the seed rather than propagating.
        if (mode_q != MODE_COUNT && !$onehot(led_q)) begin
            nxt     = seed_w;
            nxt_dir = DIR_LEFT;
        end
    end

    always_comb begin
        cnt_d  = cnt_q;
        mode_d = mode_q;
        dir_d  = dir_q;
        led_d  = led_q;
        step_d = 1'b0;
        if (!btn_db) begin
            led_d = seed_w;
            cnt_d = '0;
            dir_d = DIR_LEFT;
        end else if (mode_in != mode_q) begin
            led_d  = seed_w;
            cnt_d  = '0;
            dir_d  = DIR_LEFT;
            mode_d = mode_in;
        end else if (pause_i) begin
            cnt_d = cnt_q;
        end else if (cnt_q == CntMax) begin
            cnt_d  = '0;
            led_d  = nxt;
            dir_d  = nxt_dir;
            step_d = 1'b1;
        end else begin
            cnt_d = cnt_q + CntW'(1);
        end
    end

    assign led_o  = led_q;
    assign step_o = step_q;

endmodule

// File: tb/tb_led_pattern_gen.sv
// Self-checking bench for led_pattern_gen: vector table, corner-case sequences, random vs model.
module tb_led_pattern_gen;
    import led_pkg::*;

    localparam int NL  = 4;
    localparam int DIV = 4;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          btn;
    logic [1:0]    mode;
    logic [1:0]    mode2;
    logic          pause;
    logic [NL-1:0] led;
    logic          step;
    logic [1:0]    led2;
    logic          step2;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [1:0] mode;
        logic       pause;
        int         cycles;
        logic [3:0] led;
        logic       step;
    } vec_t;

    vec_t vecs[$];

    always #5 clk = ~clk;

    led_pattern_gen #(
        .N_LEDS    (NL),
        .DIV       (DIV),
        .DEB_CYCLES(3)
    ) dut (
        .clk_i  (clk),
        .rst_ni (rst_n),
        .btn_i  (btn),
        .mode_i (mode),
        .pause_i(pause),
        .led_o  (led),
        .step_o (step)
    );

    led_pattern_gen #(
        .N_LEDS    (2),
        .DIV       (DIV),
        .DEB_CYCLES(3)
    ) dut2 (
        .clk_i  (clk),
        .rst_ni (rst_n),
        .btn_i  (btn),
        .mode_i (mode2),
        .pause_i(pause),
        .led_o  (led2),
        .step_o (step2)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic clk_edge();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    function automatic void add(logic [1:0] m, logic p, int c, logic [3:0] l, logic s);
        vecs.push_back('{m, p, c, l, s});
    endfunction

    // Pattern after idx steps from the seed of a mode, from the mode rules directly.
    function automatic logic [3:0] model_led(int m, int idx);
        int p;
        case (m)
            0: return 4'(1 << (idx % NL));
            1: return 4'((1 << (NL - 1)) >> (idx % NL));
            2: begin
                p = idx % (2 * NL - 2);
                return 4'(1 << ((p < NL) ? p : (2 * NL - 2 - p)));
            end
            default: return 4'(idx % (1 << NL));
        endcase
    endfunction

    initial begin
        int m_mode, m_idx, m_cnt;
        logic exp_step;
        logic [3:0] bounce_seq[7];

        // ROTL wrap, BOUNCE pass, COUNT wrap, ROTR seed, pause hold
        add(MODE_ROTL, 0, 4, 4'b0010, 1);
        add(MODE_ROTL, 0, 4, 4'b0100, 1);
        add(MODE_ROTL, 0, 4, 4'b1000, 1);
        add(MODE_ROTL, 0, 4, 4'b0001, 1);
        add(MODE_BOUNCE, 0, 1, 4'b0001, 0);
        bounce_seq = '{4'b0010, 4'b0100, 4'b1000, 4'b0100, 4'b0010, 4'b0001, 4'b0010};
        foreach (bounce_seq[i]) add(MODE_BOUNCE, 0, 4, bounce_seq[i], 1);
        add(MODE_COUNT, 0, 1, 4'b0000, 0);
        for (int i = 1; i <= 16; i++) add(MODE_COUNT, 0, 4, 4'(i % 16), 1);
        add(MODE_ROTR, 0, 1, 4'b1000, 0);
        add(MODE_ROTR, 0, 4, 4'b0100, 1);
        add(MODE_ROTR, 1, 6, 4'b0100, 0);
        add(MODE_ROTR, 0, 4, 4'b0010, 1);

        rst_n = 1'b0;
        btn   = 1'b1;
        pause = 1'b0;
        mode  = MODE_ROTL;
        mode2 = MODE_COUNT;
        #12;
        check("reset_led", 32'(led), 32'h1);
        check("reset_step", 32'(step), 32'h0);
        check("reset_led2", 32'(led2), 32'h1);
        check("reset_step2", 32'(step2), 32'h0);

        // Two-LED counter: 00,01,10,11,00
        @(negedge clk);
        rst_n = 1'b1;
        clk_edge();
        check("cnt2_seed", 32'(led2), 32'h0);
        for (int s = 1; s <= 4; s++) begin
            for (int k = 1; k <= DIV; k++) begin
                clk_edge();
                if (k < DIV) check("cnt2_idle", 32'(step2), 32'h0);
            end
            check("cnt2_led", 32'(led2), 32'(s % 4));
            check("cnt2_step", 32'(step2), 32'h1);
        end

        // Vector table from a fresh reset
        mode = MODE_ROTL;
        do_reset();
        foreach (vecs[i]) begin
            mode  = vecs[i].mode;
            pause = vecs[i].pause;
            for (int k = 1; k <= vecs[i].cycles; k++) begin
                clk_edge();
                if (k < vecs[i].cycles) check("vec_idle_step", 32'(step), 32'h0);
            end
            check($sformatf("vec%0d_led", i), 32'(led), 32'(vecs[i].led));
            check($sformatf("vec%0d_step", i), 32'(step), 32'(vecs[i].step));
        end

        // Button glitch, long press, mode switch, pause, async reset
        mode  = MODE_ROTL;
        pause = 1'b0;
        btn   = 1'b0;
        do_reset();
        clk_edge();
        clk_edge();
        btn = 1'b1;
        clk_edge();
        clk_edge();
        check("glitch_led", 32'(led), 32'b0010);
        check("glitch_step", 32'(step), 32'h1);
        repeat (4) clk_edge();
        check("pre_press_led", 32'(led), 32'b0100);
        btn = 1'b0;
        for (int e = 9; e <= 28; e++) begin
            clk_edge();
            if (e == 12) check("press_lag_led", 32'(led), 32'b1000);
            if (e >= 14) begin
                check("press_led", 32'(led), 32'b0001);
                check("press_step", 32'(step), 32'h0);
            end
            if (e == 20) btn = 1'b1;
        end
        clk_edge();
        check("release_led", 32'(led), 32'b0010);
        check("release_step", 32'(step), 32'h1);

        clk_edge();
        clk_edge();
        mode = MODE_ROTR;
        for (int e = 32; e <= 35; e++) begin
            clk_edge();
            check("switch_led", 32'(led), 32'b1000);
            check("switch_step", 32'(step), 32'h0);
        end
        clk_edge();
        check("switch_next_led", 32'(led), 32'b0100);
        check("switch_next_step", 32'(step), 32'h1);

        clk_edge();
        clk_edge();
        pause = 1'b1;
        for (int e = 39; e <= 48; e++) begin
            clk_edge();
            check("pause_led", 32'(led), 32'b0100);
            check("pause_step", 32'(step), 32'h0);
        end
        pause = 1'b0;
        clk_edge();
        check("unpause_idle", 32'(step), 32'h0);
        clk_edge();
        check("unpause_led", 32'(led), 32'b0010);
        check("unpause_step", 32'(step), 32'h1);

        #2;
        rst_n = 1'b0;
        #1;
        check("async_rst_led", 32'(led), 32'b0001);
        check("async_rst_step", 32'(step), 32'h0);

        // Random mode/pause traffic against the model
        mode  = MODE_ROTL;
        pause = 1'b0;
        btn   = 1'b1;
        do_reset();
        m_mode = 0;
        m_idx  = 0;
        m_cnt  = 0;
        for (int c = 0; c < 400; c++) begin
            if ($urandom_range(15) == 0) mode = 2'($urandom_range(3));
            if ($urandom_range(7) == 0) pause = ~pause;
            clk_edge();
            exp_step = 1'b0;
            if (int'(mode) != m_mode) begin
                m_mode = int'(mode);
                m_idx  = 0;
                m_cnt  = 0;
            end else if (!pause) begin
                if (m_cnt == DIV - 1) begin
                    m_cnt    = 0;
                    m_idx++;
                    exp_step = 1'b1;
                end else begin
                    m_cnt++;
                end
            end
            check("rand_led", 32'(led), 32'(model_led(m_mode, m_idx)));
            check("rand_step", 32'(step), 32'(exp_step));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
